// File: rtl/spi_tx_src_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | spi_arb_pkg : FSM encoding and constants for the SPI source arbiter (r1.0) |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_arb_pkg;

  localparam int         N_SRC    = 3;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4
  } state_e;

  // Successor index modulo N_SRC; an out-of-range pointer restarts at source 0.
  function automatic logic [1:0] rr_next(input logic [1:0] ptr);
    return (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_src_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | spi_tx_src_arbiter_if : request/data/SPI-engine bundle of the arbiter (r1.0)|
// +----------------------------------------------------------------------------+
`default_nettype none

interface spi_tx_src_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [N_SRC-1:0]  req;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic              tx_busy;
  logic              tx_done;
  logic [1:0]        sel;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic [N_SRC-1:0]  gnt;
  logic [N_SRC-1:0]  ack;
  logic              timeout_err;

  modport master (
    input  req, in1, in2, in3, tx_busy, tx_done,
    output sel, tx_data, tx_start, gnt, ack, timeout_err
  );

  modport slave (
    output req, in1, in2, in3, tx_busy, tx_done,
    input  sel, tx_data, tx_start, gnt, ack, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/spi_tx_src_arbiter_rr_pick3.sv
// +----------------------------------------------------------------------------+
// | rr_pick3 : combinational round-robin picker, scan starts after last_ptr (r1.0)|
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick3
  import spi_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  input  logic [1:0]       last_ptr_i,
  output logic [N_SRC-1:0] gnt_nxt_o,
  output logic [1:0]       idx_nxt_o,
  output logic             valid_o
);

  always_comb begin
    logic [1:0] cand;
    gnt_nxt_o = '0;
    idx_nxt_o = SEL_NONE;
    valid_o   = 1'b0;
    cand      = rr_next(last_ptr_i);
    for (int k = 0; k < N_SRC; k++) begin
      if (!valid_o && req_i[cand]) begin
        valid_o         = 1'b1;
        idx_nxt_o       = cand;
        gnt_nxt_o[cand] = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_tx_src_arbiter.sv
// +----------------------------------------------------------------------------+
// | spi_tx_src_arbiter : 3-source round-robin byte sequencer for the SPI TX.   |
// | Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.  Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_tx_src_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
)(
  input  logic                        clk,
  input  logic                        rst_n,
  spi_tx_src_arbiter_if.master        bus
);

  state_e            state_q;
  logic [1:0]        last_ptr_q;
  logic [1:0]        sel_q;
  logic [N_SRC-1:0]  gnt_q;
  logic [N_SRC-1:0]  ack_q;
  logic [DATA_W-1:0] tx_data_q;

  logic [N_SRC-1:0]  gnt_d;
  logic [1:0]        idx_d;
  logic              req_valid;
  logic [DATA_W-1:0] data_d;
  logic              tmo_expire;

  rr_pick3 u_pick (
    .req_i      (bus.req),
    .last_ptr_i (last_ptr_q),
    .gnt_nxt_o  (gnt_d),
    .idx_nxt_o  (idx_d),
    .valid_o    (req_valid)
  );

  always_comb begin
    data_d = bus.in3;
    case (idx_d)
      2'd0:    data_d = bus.in1;
      2'd1:    data_d = bus.in2;
      default: data_d = bus.in3;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside WAIT, so the first WAIT cycle always sees 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_expire      = (state_q == ST_WAIT) && !bus.tx_done &&
                           (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.timeout_err = tmo_expire;
`else
  assign tmo_expire      = 1'b0;
  assign bus.timeout_err = 1'b0 & (TIMEOUT_CYC < 2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_ptr_q <= 2'd2;
      sel_q      <= SEL_NONE;
      gnt_q      <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            gnt_q     <= gnt_d;
            sel_q     <= idx_d;
            tx_data_q <= data_d;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= ST_START;
        end
        ST_START: begin
          if (!bus.tx_busy) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.tx_done) begin
            ack_q   <= gnt_q;
            state_q <= ST_ACK;
          end else if (tmo_expire) begin
            last_ptr_q <= sel_q;
            gnt_q      <= '0;
            sel_q      <= SEL_NONE;
            state_q    <= ST_IDLE;
          end
        end
        ST_ACK: begin
          last_ptr_q <= sel_q;
          gnt_q      <= '0;
          sel_q      <= SEL_NONE;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The start pulse must land in the very cycle the engine reports idle.
  assign bus.tx_start = (state_q == ST_START) && !bus.tx_busy;
  assign bus.sel      = sel_q;
  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.tx_data  = tx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_src_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_spi_tx_src_arbiter : self-checking bench for spi_tx_src_arbiter (r1.0)  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_tx_src_arbiter;

  localparam int DATA_W = 8;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_last = 2;
  logic [7:0] src [3];

  spi_tx_src_arbiter_if #(.DATA_W(DATA_W)) bus ();

  spi_tx_src_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: first requesting source strictly after the last served one.
  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that starts an IDLE cycle; returns in START after tx_start.
  task automatic begin_xfer(input logic [2:0] r, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input int busy, output int idx);
    bus.req = r; bus.in1 = d1; bus.in2 = d2; bus.in3 = d3;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    src[0] = d1; src[1] = d2; src[2] = d3;
    idx = pick(r, model_last);
    @(negedge clk);
    chk("idle_out", {bus.ack, bus.gnt, bus.sel, bus.tx_start}, {3'b000, 3'b000, 2'd3, 1'b0});
    nxt();
    bus.in1 = d1 + 8'h11; bus.in2 = d2 + 8'h11; bus.in3 = d3 + 8'h11;
    bus.req = r & 3'($urandom);
    bus.tx_busy = (busy > 0);
    @(negedge clk);
    chk("load_gnt", bus.gnt, 32'(1) << idx);
    chk("load_sel", bus.sel, idx);
    chk("load_data", bus.tx_data, src[idx]);
    chk("load_nostart", bus.tx_start, 0);
    nxt();
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      chk("stall_start", bus.tx_start, 0);
      chk("stall_data", bus.tx_data, src[idx]);
      nxt();
      bus.tx_busy = (i < busy - 1);
    end
    @(negedge clk);
    chk("tx_start", bus.tx_start, 1);
    chk("start_sel", bus.sel, idx);
  endtask

  // tx_done arrives k cycles after tx_start; returns at the start of the IDLE cycle.
  task automatic end_xfer(input int idx, input int k);
    for (int i = 1; i < k; i++) begin
      nxt();
      @(negedge clk);
      chk("wait_hold", {bus.ack, bus.tx_start, bus.gnt}, {3'b000, 1'b0, 3'(32'(1) << idx)});
    end
    nxt();
    bus.tx_done = 1'b1;
    @(negedge clk);
    chk("done_noack", bus.ack, 0);
    nxt();
    bus.tx_done = 1'b0;
    @(negedge clk);
    chk("ack", bus.ack, 32'(1) << idx);
    chk("ack_gnt", bus.gnt, 32'(1) << idx);
    model_last = idx;
    nxt();
  endtask

  initial begin
    int idx;
    rst_n = 1'b0;
    bus.req = 3'b111; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0;

    // Reset values with all requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", bus.sel, 3);
    chk("rst_gnt_ack", {bus.gnt, bus.ack}, 0);
    chk("rst_start_err", {bus.tx_start, bus.timeout_err}, 0);
    chk("rst_data", bus.tx_data, 0);
    nxt();
    rst_n = 1'b1;

    // Fairness with all requests held: 0,1,2,0,1,2,0
    for (int i = 0; i < 7; i++) begin
      begin_xfer(3'b111, 8'($urandom), 8'($urandom), 8'($urandom), 0, idx);
      chk("rr_gnt", bus.gnt, 32'(1) << (i % 3));
      end_xfer(idx, 5);
    end

    // Single request on source 1
    begin_xfer(3'b010, 8'h3C, 8'hA5, 8'h5A, 0, idx);
    end_xfer(idx, 3);

    // Busy stall with data change after capture
    begin_xfer(3'b001, 8'h11, 8'h77, 8'h88, 10, idx);
    chk("hold_data", bus.tx_data, 8'h11);
    end_xfer(idx, 2);

    // Reset in WAIT: no ack, priority restarts at source 0
    begin_xfer(3'b100, 8'h01, 8'h02, 8'h03, 0, idx);
    nxt();
    @(negedge clk);
    chk("prerst_wait", bus.gnt, 32'(1) << idx);
    #2 rst_n = 1'b0;
    bus.tx_done = 1'b1;
    #1;
    chk("midrst_out", {bus.ack, bus.gnt, bus.sel, bus.tx_start}, {3'b000, 3'b000, 2'd3, 1'b0});
    chk("midrst_data", bus.tx_data, 0);
    nxt();
    bus.tx_done = 1'b0;
    rst_n = 1'b1;
    model_last = 2;
    begin_xfer(3'b111, 8'h44, 8'h55, 8'h66, 0, idx);
    chk("post_rst_gnt", bus.gnt, 3'b001);
    end_xfer(idx, 1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no tx_done, error pulse TMO cycles after tx_start
    begin_xfer(3'b110, 8'h10, 8'h20, 8'h30, 0, idx);
    for (int i = 1; i <= TMO; i++) begin
      nxt();
      bus.req = 3'b000;
      @(negedge clk);
      chk("tmo_pulse", {bus.timeout_err, bus.ack}, {(i == TMO), 3'b000});
    end
    nxt();
    @(negedge clk);
    chk("tmo_after", {bus.timeout_err, bus.ack, bus.gnt, bus.sel}, {1'b0, 3'b000, 3'b000, 2'd3});
    model_last = idx;
    nxt();
    begin_xfer(3'b111, 8'h10, 8'h20, 8'h30, 0, idx);
    end_xfer(idx, 2);
`else
    // No watchdog: WAIT holds indefinitely
    begin_xfer(3'b110, 8'h10, 8'h20, 8'h30, 0, idx);
    for (int i = 0; i < 110; i++) begin
      nxt();
      @(negedge clk);
      chk("nowd_hold", {bus.timeout_err, bus.ack, bus.gnt}, {1'b0, 3'b000, 3'(32'(1) << idx)});
    end
    end_xfer(idx, 1);
`endif

    // Randomized traffic against the reference picker
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = 3'b000;
        @(negedge clk);
        chk("idle_nogrant", {bus.gnt, bus.sel}, {3'b000, 2'd3});
        nxt();
      end
      begin_xfer(3'($urandom_range(1, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 3)), idx);
      end_xfer(idx, int'($urandom_range(1, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
